// File: rtl/libar_pkg.sv
// Shared types and constants for the activity-triggered key array.
package libar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } libar_state_e;

    localparam logic [3:0] DEF_INV_MASK  = 4'b0000;
    localparam logic [3:0] DEF_RESET_KEY = 4'b0000;

    // The bit counter must be able to hold the value KEY_W.
    function automatic int cnt_width(input int kw);
        return (kw < 1) ? 1 : $clog2(kw + 1);
    endfunction

endpackage

// File: rtl/libar_bit_cell.sv
// One key slice: trigger edge detect, active key bit, sticky promoted flag and key gate.
module libar_bit_cell #(
    parameter logic INV     = 1'b0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr_promoted,
    input  logic shadow_bit,
    input  logic trig,
    input  logic net_in,
    output logic net_out,
    output logic promoted
);

    logic trig_q_r;
    logic active_r;
    logic promoted_r;
    logic rise_s;

    assign rise_s = trig & ~trig_q_r;

    // Trigger history every cycle; promotion only on a fresh rise while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q_r   <= 1'b0;
            active_r   <= RST_VAL;
            promoted_r <= 1'b0;
        end else begin
            trig_q_r <= trig;
            if (en && rise_s) begin
                active_r   <= shadow_bit;
                promoted_r <= 1'b1;
            end else if (clr_promoted) begin
                promoted_r <= 1'b0;
            end
        end
    end

    assign net_out  = net_in ^ active_r ^ INV;
    assign promoted = promoted_r;

endmodule

// File: rtl/libar_key_array.sv
// Serially loaded key array whose bits are applied on rising edges of internal trigger nets.
module libar_key_array
    import libar_pkg::*;
#(
    parameter int              KEY_W     = 4,
    parameter logic [KEY_W-1:0] INV_MASK  = KEY_W'(DEF_INV_MASK),
    parameter logic [KEY_W-1:0] RESET_KEY = KEY_W'(DEF_RESET_KEY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] trig,
    input  logic [KEY_W-1:0] net_in,
    output logic [KEY_W-1:0] net_out,
    output logic             armed,
    output logic [KEY_W-1:0] promoted
);

    localparam int CNT_W = cnt_width(KEY_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

    libar_state_e     state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [KEY_W-1:0] shadow_r, shadow_nx;
    logic             armed_r;
    logic             clr_prom_s;

    // State, counter, shadow and armed flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            shadow_r <= {KEY_W{1'b0}};
            armed_r  <= 1'b0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            shadow_r <= shadow_nx;
            armed_r  <= (state_nx == ARMED);
        end
    end

    // Next-state logic; load_start always beats an incoming key bit.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        shadow_nx  = shadow_r;
        clr_prom_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_nx = LOAD;
                    cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                if (load_start) begin
                    cnt_nx = {CNT_W{1'b0}};
                end else if (key_valid) begin
                    for (int i = 0; i < KEY_W; i++) begin
                        if (cnt_r == CNT_W'(i)) begin
                            shadow_nx[i] = key_bit;
                        end else begin
                            shadow_nx[i] = shadow_r[i];
                        end
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_nx   = ARMED;
                        cnt_nx     = {CNT_W{1'b0}};
                        clr_prom_s = 1'b1;
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            ARMED: begin
                if (load_start) begin
                    state_nx = LOAD;
                    cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    state_nx = ARMED;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign key_ready = (state_r == LOAD);
    assign armed     = armed_r;

    for (genvar g = 0; g < KEY_W; g++) begin : g_cell
        libar_bit_cell #(
            .INV     (INV_MASK[g]),
            .RST_VAL (RESET_KEY[g])
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (state_r == ARMED),
            .clr_promoted (clr_prom_s),
            .shadow_bit   (shadow_r[g]),
            .trig         (trig[g]),
            .net_in       (net_in[g]),
            .net_out      (net_out[g]),
            .promoted     (promoted[g])
        );
    end

endmodule

// File: tb/tb_libar_key_array.sv
// Directed and randomized bench for libar_key_array against a cycle-level reference model.
module tb_libar_key_array;

    localparam logic [3:0] INV = 4'b0101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [3:0] trig = 4'b0000;
    logic [3:0] net_in = 4'b0000;
    logic [3:0] net_out;
    logic       armed;
    logic [3:0] promoted;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 loading, 2 armed
    int         m_mode = 0;
    int         m_cnt = 0;
    logic [3:0] m_shadow = 4'b0000;
    logic [3:0] m_key = 4'b0000;
    logic [3:0] m_prom = 4'b0000;
    logic [3:0] m_tq = 4'b0000;

    always #5 clk = ~clk;

    libar_key_array #(
        .KEY_W     (4),
        .INV_MASK  (INV),
        .RESET_KEY (4'b0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .trig       (trig),
        .net_in     (net_in),
        .net_out    (net_out),
        .armed      (armed),
        .promoted   (promoted)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_shadow = 4'b0000; m_key = 4'b0000;
        m_prom = 4'b0000; m_tq = 4'b0000;
    endtask

    // One clock: drive, check combinational outputs, clock model and DUT, check registered outputs.
    task automatic tick(input logic ls, input logic kv, input logic kb,
                        input logic [3:0] tg, input logic [3:0] ni);
        load_start = ls; key_valid = kv; key_bit = kb; trig = tg; net_in = ni;
        #1;
        check("key_ready", {7'd0, key_ready}, {7'd0, (m_mode == 1)});
        check("net_out_pre", {4'd0, net_out}, {4'd0, ni ^ m_key ^ INV});
        for (int i = 0; i < 4; i++) begin
            if (m_mode == 2 && tg[i] && !m_tq[i]) begin
                m_key[i]  = m_shadow[i];
                m_prom[i] = 1'b1;
            end
        end
        m_tq = tg;
        if (m_mode == 0) begin
            if (ls) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (ls) m_cnt = 0;
            else if (kv) begin
                m_shadow[m_cnt] = kb;
                m_cnt++;
                if (m_cnt == 4) begin m_mode = 2; m_cnt = 0; m_prom = 4'b0000; end
            end
        end else begin
            if (ls) begin m_mode = 1; m_cnt = 0; end
        end
        @(posedge clk);
        #1;
        check("armed", {7'd0, armed}, {7'd0, (m_mode == 2)});
        check("promoted", {4'd0, promoted}, {4'd0, m_prom});
        check("net_out", {4'd0, net_out}, {4'd0, ni ^ m_key ^ INV});
    endtask

    task automatic load4(input logic [3:0] k, input logic [3:0] tg);
        tick(1'b1, 1'b0, 1'b0, tg, 4'b0000);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, k[i], tg, 4'b0000);
    endtask

    initial begin
        // Reset state, no clock edge needed
        #3;
        check("rst_net_out", {4'd0, net_out}, 8'h05);
        check("rst_armed", {7'd0, armed}, 8'h00);
        check("rst_ready", {7'd0, key_ready}, 8'h00);
        check("rst_promoted", {4'd0, promoted}, 8'h00);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Load 1,0,1,1 with trig[3] held high from LOAD into ARMED
        load4(4'b1101, 4'b1000);
        check("armed_after_load", {7'd0, armed}, 8'h01);
        check("no_promo_held_trig", {4'd0, promoted}, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000);
        tick(1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000);
        tick(1'b0, 1'b0, 1'b0, 4'b1100, 4'b0000);
        check("promoted_0101", {4'd0, promoted}, 8'h05);
        check("net_out_0000", {4'd0, net_out}, 8'h00);
        // Bit 3 only after its trigger falls and rises again
        tick(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000);
        check("promoted_bit3", {4'd0, promoted}, 8'h0D);

        // Restart after two bits, and load_start with key_valid accepts nothing
        tick(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        tick(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        tick(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);
        check("key_1000", {4'd0, net_out}, 8'h0D);

        // Full key 1111, then asynchronous reset mid-cycle
        load4(4'b1111, 4'b0000);
        tick(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011);
        check("key_1111", {4'd0, net_out}, 8'h09);
        #2 rst_n = 1'b0;
        #1;
        check("async_net_out", {4'd0, net_out}, 8'h06);
        check("async_promoted", {4'd0, promoted}, 8'h00);
        check("async_armed", {7'd0, armed}, 8'h00);
        check("async_ready", {7'd0, key_ready}, 8'h00);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/libar_key_array.md
Name: libar_key_array

Overview:
- Parametrised successor to the single-bit, internally-triggered key latches used in the locked c17 netlists.
- Holds a KEY_W-bit key. The key is loaded serially into a shadow register through a valid/ready handshake.
- Each bit is promoted into its active key register only on a rising edge of its own internal trigger net, so key application depends on circuit activity (LIBAR style).
- The active key drives XOR/XNOR key gates on KEY_W internal nets, with one lock-gate bank. Clocking is synchronous; the original gate-driven DFF clocks are replaced by edge detects.

Parameters:
- KEY_W, 4, number of key bits / key gates / trigger nets (1..64).
- INV_MASK, 4'b0000 (KEY_W bits), per-bit gate type: 0 = XOR, 1 = XNOR.
- RESET_KEY, 4'b0000 (KEY_W bits), active-key value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that begins a serial key load.
- key_bit  in  1  serial key data, LSB first.
- key_valid  in  1  key_bit is valid this cycle.
- key_ready  out  1  block accepts key_bit this cycle.
- trig  in  KEY_W  internal trigger nets; trig[i] gates promotion of bit i.
- net_in  in  KEY_W  unlocked internal nets entering the key gates.
- net_out  out  KEY_W  locked nets: net_in ^ active_key ^ INV_MASK.
- armed  out  1  a full shadow key is loaded and promotion is enabled.
- promoted  out  KEY_W  sticky per-bit flag: bit i has been promoted since the last arm.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE, bit counter = 0, shadow = 0, active_key = RESET_KEY, trig_q = 0.
  - key_ready = 0, armed = 0, promoted = 0.
  - net_out = net_in ^ RESET_KEY ^ INV_MASK (combinational, valid during reset).
- States: IDLE, LOAD, ARMED.
- IDLE:
  - key_ready = 0.
  - load_start -> LOAD, counter cleared.
- LOAD:
  - key_ready = 1.
  - On key_valid && key_ready: shadow[cnt] <= key_bit, cnt++.
  - When the KEY_W-th bit is accepted -> ARMED on the next edge. armed = 1 starting the cycle after the last accept; promoted is cleared on the same edge.
  - load_start in LOAD restarts: cnt = 0; the partial shadow is discarded, not cleared.
  - Simultaneous load_start and key_valid: load_start wins and the bit is not accepted.
- ARMED:
  - key_ready = 0.
  - Per bit i: rise_i = trig[i] & ~trig_q[i].
  - If rise_i: active_key[i] <= shadow[i] and promoted[i] <= 1.
  - Repeated rises re-copy the same value, which is harmless.
  - load_start -> LOAD and armed drops next cycle; active_key is retained; promoted holds until the next arm.
- Triggers outside ARMED:
  - Never modify active_key.
  - trig_q samples trig every cycle regardless of state, so a trig held high when entering ARMED does not count as a rise.
- Counter width: clog2(KEY_W+1). Terminal compare is cnt == KEY_W-1 with an accept.
- Latency:
  - Promotion takes one cycle: rising edge of trig seen at edge N -> active_key and net_out updated after edge N.
  - net_out is otherwise purely combinational from net_in.
- Mid-operation reset discards the shadow and restores RESET_KEY immediately (async).
- All outputs are registered except net_out and key_ready, which decodes state.

Decomposition:
- Package libar_pkg:
  - state enum (IDLE, LOAD, ARMED);
  - a function computing the counter width;
  - default INV_MASK / RESET_KEY constants.
- One sub-module libar_bit_cell, instantiated KEY_W times. It holds trig_q, the active bit and the promoted flag, plus the XOR/XNOR gate selected by its INV bit.
- The top level holds the FSM, counter and shadow.

Test Plan:
1. Reset, KEY_W=4, INV_MASK=4'b0101, RESET_KEY=0, net_in=4'b0000 -> net_out=4'b0101, armed=0, key_ready=0.
2. load_start, then serial bits 1,0,1,1 with continuous valid -> key_ready high for 4 cycles; armed=1 on the cycle after the 4th accept; net_out unchanged until triggers fire.
3. Armed with shadow=4'b1101, pulse trig=4'b0001 then trig=4'b0100 -> active_key=4'b0101 after the second edge; promoted=4'b0101; net_in=0 gives net_out=4'b0000.
4. trig[3] held high from LOAD into ARMED -> no promotion of bit 3 until trig[3] falls and rises again.
5. load_start after two accepted bits, then a full 4-bit load of 0,0,0,1 -> shadow=4'b1000; partial bits discarded; load_start asserted together with key_valid accepts no bit.
6. rst_n asserted while ARMED with active_key=4'b1111 -> active_key=RESET_KEY immediately, without a clock edge; state=IDLE; promoted=0.
